// File: rtl/arrow_spawn_scheduler_if.sv
// Bundle between the arrow spawn scheduler, the pattern ROM, the phase FSM and the arrow pool.
// The master modport is the scheduler side; the slave modport is its environment.
interface arrow_spawn_scheduler_if #(
    parameter int unsigned NUM_SLOTS = 24
);
    logic                 start_in;
    logic                 abort_in;
    logic [4:0]           event_addr_out;
    logic [7:0]           event_data_in;
    logic [NUM_SLOTS-1:0] slot_busy_in;
    logic [NUM_SLOTS-1:0] spawn_out;
    logic [1:0]           spawn_dir_out;
    logic [1:0]           spawn_speed_out;
    logic                 spawn_inv_out;
    logic                 busy_out;
    logic                 finished_out;
    logic [7:0]           dropped_out;

    modport master (
        input  start_in, abort_in, event_data_in, slot_busy_in,
        output event_addr_out, spawn_out, spawn_dir_out, spawn_speed_out, spawn_inv_out,
        output busy_out, finished_out, dropped_out
    );

    modport slave (
        output start_in, abort_in, event_data_in, slot_busy_in,
        input  event_addr_out, spawn_out, spawn_dir_out, spawn_speed_out, spawn_inv_out,
        input  busy_out, finished_out, dropped_out
    );
endinterface

// File: rtl/arrow_spawn_scheduler.sv
// Dodge-phase sequencer: walks the arrow pattern table, waits each event's delay, allocates the
// lowest free arrow slot and fires a one-cycle spawn. Ends once the table is exhausted and every
// slot has drained.
module arrow_spawn_scheduler #(
    parameter int unsigned NUM_SLOTS   = 24,
    parameter int unsigned MAX_EVENTS  = 24,
    parameter int unsigned TICK_CYCLES = 6500000
) (
    input logic clk,
    input logic rst,
    arrow_spawn_scheduler_if.master bus
);
    localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StAlloc, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [4:0]           index_q, index_d;
    logic                 fetch_lat_q, fetch_lat_d;  // second FETCH cycle: ROM data is valid
    logic [7:0]           evt_q, evt_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [2:0]           unit_q, unit_d;
    logic [NUM_SLOTS-1:0] pending_q, pending_d;      // allocated, arrow valid not yet seen
    logic                 busy_q, busy_d;
    logic [7:0]           dropped_q, dropped_d;

    logic [NUM_SLOTS-1:0] free;
    logic [NUM_SLOTS-1:0] alloc_oh;

    // Free slots and the lowest one among them (x & -x isolates the lowest set bit).
    always_comb begin
        free     = ~bus.slot_busy_in & ~pending_q;
        alloc_oh = free & (~free + 1'b1);
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        fetch_lat_d = fetch_lat_q;
        evt_d       = evt_q;
        tick_d      = tick_q;
        unit_d      = unit_q;
        pending_d   = pending_q & ~bus.slot_busy_in;
        busy_d      = busy_q;
        dropped_d   = dropped_q;

        bus.event_addr_out  = '0;
        bus.spawn_out       = '0;
        bus.spawn_dir_out   = '0;
        bus.spawn_speed_out = '0;
        bus.spawn_inv_out   = 1'b0;
        bus.finished_out    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_in) begin
                    index_d     = '0;
                    dropped_d   = '0;
                    busy_d      = 1'b1;
                    fetch_lat_d = 1'b0;
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                if (bus.abort_in) begin
                    state_d = StDrain;
                end else if (!fetch_lat_q) begin
                    bus.event_addr_out = index_q;
                    fetch_lat_d        = 1'b1;
                end else begin
                    fetch_lat_d = 1'b0;
                    evt_d       = bus.event_data_in;
                    tick_d      = '0;
                    unit_d      = '0;
                    if (bus.event_data_in[7:5] == 3'd0 || index_q == 5'(MAX_EVENTS)) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (bus.abort_in) begin
                    state_d = StDrain;
                end else if (tick_q == TickW'(TICK_CYCLES - 1)) begin
                    tick_d = '0;
                    unit_d = unit_q + 3'd1;
                    if (unit_q + 3'd1 == evt_q[7:5]) begin
                        state_d = StAlloc;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StAlloc: begin
                if (bus.abort_in) begin
                    state_d = StDrain;
                end else begin
                    if (|free) begin
                        bus.spawn_out       = alloc_oh;
                        bus.spawn_dir_out   = evt_q[4:3];
                        bus.spawn_speed_out = evt_q[2:1];
                        bus.spawn_inv_out   = evt_q[0];
                        pending_d           = pending_d | alloc_oh;
                    end else if (dropped_q != 8'hFF) begin
                        dropped_d = dropped_q + 8'd1;
                    end
                    index_d     = index_q + 5'd1;
                    fetch_lat_d = 1'b0;
                    state_d     = StFetch;
                end
            end
            StDrain: begin
                if (bus.slot_busy_in == '0 && pending_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bus.finished_out = 1'b1;
                busy_d           = 1'b0;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            index_q     <= '0;
            fetch_lat_q <= 1'b0;
            evt_q       <= '0;
            tick_q      <= '0;
            unit_q      <= '0;
            pending_q   <= '0;
            busy_q      <= 1'b0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            fetch_lat_q <= fetch_lat_d;
            evt_q       <= evt_d;
            tick_q      <= tick_d;
            unit_q      <= unit_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            dropped_q   <= dropped_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        bus.busy_out    = busy_q;
        bus.dropped_out = dropped_q;
    end
endmodule

// File: tb/tb_arrow_spawn_scheduler.sv
// Directed bench for arrow_spawn_scheduler with TICK_CYCLES=4, NUM_SLOTS=3, a sync pattern ROM
// and a simple arrow-pool model (configurable valid lag and lifetime per spawn).
module tb_arrow_spawn_scheduler;
    localparam int unsigned NS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arrow_spawn_scheduler_if #(.NUM_SLOTS(NS)) bus ();

    arrow_spawn_scheduler #(
        .NUM_SLOTS  (NS),
        .MAX_EVENTS (24),
        .TICK_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Pattern ROM, one-cycle read latency.
    logic [7:0] rom [32];
    logic [7:0] rom_q;
    always @(posedge clk) rom_q <= rom[bus.event_addr_out];
    assign bus.event_data_in = rom_q;

    // Arrow pool model: valid rises lag+1 cycles after spawn and stays up for life cycles.
    int dly [NS];
    int cnt [NS];
    int lag_cfg [NS];
    int life = 5;
    bit force_busy = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (rst) begin
                dly[i] <= 0;
                cnt[i] <= 0;
            end else if (bus.spawn_out[i]) begin
                dly[i] <= lag_cfg[i];
                cnt[i] <= life;
            end else if (dly[i] > 0) begin
                dly[i] <= dly[i] - 1;
            end else if (cnt[i] > 0) begin
                cnt[i] <= cnt[i] - 1;
            end
        end
    end

    always_comb begin
        bus.slot_busy_in = '0;
        for (int i = 0; i < NS; i++) begin
            bus.slot_busy_in[i] = force_busy | (dly[i] == 0 && cnt[i] > 0);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Observation log, cycle t counted from the first cycle after start_in.
    int         t;
    int         n_spawn;
    int         n_fin;
    int         fin_t;
    int         sp_t     [64];
    logic [2:0] sp_slot  [64];
    logic [4:0] sp_attr  [64];  // {dir, speed, inv}

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (bus.spawn_out != '0 && n_spawn < 64) begin
                sp_t[n_spawn]    = t;
                sp_slot[n_spawn] = bus.spawn_out;
                sp_attr[n_spawn] = {bus.spawn_dir_out, bus.spawn_speed_out, bus.spawn_inv_out};
                n_spawn++;
            end
            if (bus.finished_out) begin
                n_fin++;
                fin_t = t;
            end
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic kick(input bit with_abort);
        bus.start_in = 1'b1;
        bus.abort_in = with_abort;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;
        t       = 1;
        n_spawn = 0;
        n_fin   = 0;
        fin_t   = -1;
    endtask

    task automatic load_table(input logic [7:0] fill, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        for (int i = 0; i < 32; i++) rom[i] = fill;
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
        rom[3] = e3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (bus.busy_out !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy got %b want 0", bus.busy_out); end
        n_tests++; if (bus.finished_out !== 1'b0) begin n_fail++;
            $display("FAIL reset_finished got %b want 0", bus.finished_out); end
        n_tests++; if (bus.spawn_out !== 3'b000) begin n_fail++;
            $display("FAIL reset_spawn got %b want 000", bus.spawn_out); end
        n_tests++; if (bus.dropped_out !== 8'd0) begin n_fail++;
            $display("FAIL reset_dropped got %0d want 0", bus.dropped_out); end
        n_tests++; if (bus.event_addr_out !== 5'd0) begin n_fail++;
            $display("FAIL reset_addr got %0d want 0", bus.event_addr_out); end
    endtask

    // Three events: delay 2, 2, 1 then end marker; long-lived arrows force distinct slots.
    task automatic test_pattern();
        load_table(8'h00, 8'h40, 8'h5B, 8'h20, 8'h00);
        life = 20;
        kick(1'b0);
        n_tests++; if (bus.busy_out !== 1'b1) begin n_fail++;
            $display("FAIL pattern_busy_start got %b want 1", bus.busy_out); end
        n_tests++; if (bus.event_addr_out !== 5'd0) begin n_fail++;
            $display("FAIL pattern_addr0 got %0d want 0", bus.event_addr_out); end
        run(60);
        n_tests++; if (n_spawn !== 3) begin n_fail++;
            $display("FAIL pattern_nspawn got %0d want 3", n_spawn); end
        n_tests++; if (sp_t[0] !== 11 || sp_slot[0] !== 3'b001 || sp_attr[0] !== 5'b00_00_0) begin
            n_fail++;
            $display("FAIL pattern_spawn0 got t=%0d slot=%b attr=%b want t=11 slot=001 attr=00000",
                     sp_t[0], sp_slot[0], sp_attr[0]); end
        n_tests++; if (sp_t[1] !== 22 || sp_slot[1] !== 3'b010 || sp_attr[1] !== 5'b11_01_1) begin
            n_fail++;
            $display("FAIL pattern_spawn1 got t=%0d slot=%b attr=%b want t=22 slot=010 attr=11011",
                     sp_t[1], sp_slot[1], sp_attr[1]); end
        n_tests++; if (sp_t[2] !== 29 || sp_slot[2] !== 3'b100 || sp_attr[2] !== 5'b00_00_0) begin
            n_fail++;
            $display("FAIL pattern_spawn2 got t=%0d slot=%b attr=%b want t=29 slot=100 attr=00000",
                     sp_t[2], sp_slot[2], sp_attr[2]); end
        n_tests++; if (n_fin !== 1 || fin_t !== 51) begin n_fail++;
            $display("FAIL pattern_finished got n=%0d t=%0d want n=1 t=51", n_fin, fin_t); end
        n_tests++; if (bus.busy_out !== 1'b0) begin n_fail++;
            $display("FAIL pattern_busy_end got %b want 0", bus.busy_out); end
    endtask

    // Every slot busy: both events drop, finish waits for the pool to empty.
    task automatic test_all_busy();
        load_table(8'h00, 8'h20, 8'h20, 8'h00, 8'h00);
        life       = 5;
        force_busy = 1'b1;
        kick(1'b0);
        run(25);
        n_tests++; if (n_spawn !== 0) begin n_fail++;
            $display("FAIL busy_nspawn got %0d want 0", n_spawn); end
        n_tests++; if (bus.dropped_out !== 8'd2) begin n_fail++;
            $display("FAIL busy_dropped got %0d want 2", bus.dropped_out); end
        n_tests++; if (n_fin !== 0) begin n_fail++;
            $display("FAIL busy_early_finish got %0d want 0", n_fin); end
        force_busy = 1'b0;
        run(10);
        n_tests++; if (n_fin !== 1 || fin_t !== 27) begin n_fail++;
            $display("FAIL busy_finished got n=%0d t=%0d want n=1 t=27", n_fin, fin_t); end
    endtask

    // Slot0's valid lags well behind its spawn; the next event must not reuse slot0.
    task automatic test_pending();
        load_table(8'h00, 8'h20, 8'h20, 8'h00, 8'h00);
        life       = 10;
        lag_cfg[0] = 8;
        kick(1'b0);
        run(35);
        lag_cfg[0] = 0;
        n_tests++; if (n_spawn !== 2) begin n_fail++;
            $display("FAIL pending_nspawn got %0d want 2", n_spawn); end
        n_tests++; if (sp_t[0] !== 7 || sp_slot[0] !== 3'b001) begin n_fail++;
            $display("FAIL pending_spawn0 got t=%0d slot=%b want t=7 slot=001",
                     sp_t[0], sp_slot[0]); end
        n_tests++; if (sp_t[1] !== 14 || sp_slot[1] !== 3'b010) begin n_fail++;
            $display("FAIL pending_spawn1 got t=%0d slot=%b want t=14 slot=010",
                     sp_t[1], sp_slot[1]); end
        n_tests++; if (n_fin !== 1 || fin_t !== 27) begin n_fail++;
            $display("FAIL pending_finished got n=%0d t=%0d want n=1 t=27", n_fin, fin_t); end
    endtask

    // Start+abort together in IDLE (start wins), ignored restart, then abort in WAIT of event 1.
    task automatic test_abort();
        load_table(8'h00, 8'h20, 8'h20, 8'h20, 8'h00);
        life = 5;
        kick(1'b1);
        n_tests++; if (bus.busy_out !== 1'b1) begin n_fail++;
            $display("FAIL abort_start_wins got %b want 1", bus.busy_out); end
        run(3);
        bus.start_in = 1'b1;
        run(1);
        bus.start_in = 1'b0;
        run(6);
        bus.abort_in = 1'b1;
        run(1);
        bus.abort_in = 1'b0;
        run(25);
        n_tests++; if (n_spawn !== 1 || sp_t[0] !== 7 || sp_slot[0] !== 3'b001) begin n_fail++;
            $display("FAIL abort_spawns got n=%0d t=%0d slot=%b want n=1 t=7 slot=001",
                     n_spawn, sp_t[0], sp_slot[0]); end
        n_tests++; if (n_fin !== 1 || fin_t !== 14) begin n_fail++;
            $display("FAIL abort_finished got n=%0d t=%0d want n=1 t=14", n_fin, fin_t); end
    endtask

    // Reset in WAIT of event 1 after one drop: outputs clear at once and the phase never ends.
    task automatic test_reset_mid();
        load_table(8'h00, 8'h20, 8'h40, 8'h00, 8'h00);
        force_busy = 1'b1;
        kick(1'b0);
        run(11);
        n_tests++; if (bus.dropped_out !== 8'd1) begin n_fail++;
            $display("FAIL rstmid_dropped_before got %0d want 1", bus.dropped_out); end
        rst = 1'b1;
        run(1);
        rst        = 1'b0;
        force_busy = 1'b0;
        n_tests++; if (bus.busy_out !== 1'b0 || bus.dropped_out !== 8'd0 ||
                       bus.spawn_out !== 3'b000 || bus.finished_out !== 1'b0 ||
                       bus.event_addr_out !== 5'd0) begin n_fail++;
            $display("FAIL rstmid_outputs got busy=%b drop=%0d spawn=%b fin=%b addr=%0d want all 0",
                     bus.busy_out, bus.dropped_out, bus.spawn_out, bus.finished_out,
                     bus.event_addr_out); end
        run(30);
        n_tests++; if (n_fin !== 0 || n_spawn !== 0 || bus.busy_out !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_idle got fin=%0d spawn=%0d busy=%b want 0 0 0",
                     n_fin, n_spawn, bus.busy_out); end
    endtask

    // 24 delay-1 events with no end marker: stops at index 24.
    task automatic test_full_table();
        load_table(8'h20, 8'h20, 8'h20, 8'h20, 8'h20);
        life = 2;
        kick(1'b0);
        run(185);
        n_tests++; if (n_spawn !== 24) begin n_fail++;
            $display("FAIL full_nspawn got %0d want 24", n_spawn); end
        n_tests++; if (sp_t[23] !== 168 || sp_slot[23] !== 3'b001) begin n_fail++;
            $display("FAIL full_last_spawn got t=%0d slot=%b want t=168 slot=001",
                     sp_t[23], sp_slot[23]); end
        n_tests++; if (n_fin !== 1 || fin_t !== 172) begin n_fail++;
            $display("FAIL full_finished got n=%0d t=%0d want n=1 t=172", n_fin, fin_t); end
    endtask

    initial begin
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;
        for (int i = 0; i < NS; i++) lag_cfg[i] = 0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        test_reset();
        test_pattern();
        test_all_busy();
        test_pending();
        test_abort();
        test_reset_mid();
        test_full_table();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
